matrix_addr_reader: RTL and testbench
=====================================

// Module: matrix_addr_reader
// PURPOSE
//  Read-side address sequencer for matrix buffers filled by the linear row/col write counter.
//  On start, walks every element of a (row_max+1) x (col_max+1) matrix in row-major or column-major order.
//  Presents row, col and linearised address a = (row << log2(col_max+1)) | col on a valid/ready stream.
//  Column-major order gives the transposed operand fetch for the MACC array.
// PARAMETERS
//  MSB  11  MSB index of the address/row/col buses (width MSB+1)
// PORTS
//  CLK        in   1      clock, rising edge
//  RST_L      in   1      reset, asynchronous, active-low
//  start      in   1      begin a scan; sampled only in IDLE
//  row_max    in   MSB+1  last row index; sampled on accepted start
//  col_max    in   MSB+1  last col index, 2^k-1 (0,1,3,7,...); sampled on accepted start
//  col_major  in   1      0: col varies fastest; 1: row varies fastest; sampled on accepted start
//  out_ready  in   1      consumer accepts current beat
//  out_valid  out  1      a/row/col/last hold a valid beat
//  a          out  MSB+1  linearised address of current beat
//  row        out  MSB+1  row index of current beat
//  col        out  MSB+1  col index of current beat
//  last       out  1      current beat is final element of scan
//  busy       out  1      high in RUN
//  done       out  1      one-cycle pulse after final beat accepted
// BEHAVIOUR
//  Reset (async, RST_L=0): state IDLE.
//   All outputs 0; latched row_max/col_max/col_major/shift cleared.
//   Reset mid-scan aborts immediately: no done pulse, out_valid low.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 latches config.
//    shift = number of trailing ones in col_max (0 when col_max=0).
//    row=col=a=0, out_valid=1, busy=1 from the next cycle. Next state RUN.
//   RUN: beat accepted when out_valid & out_ready; out_valid stays high, beat held stable until accepted.
//    Row-major advance: col++; at col==col_max, col=0 and row++.
//    Col-major advance: row++; at row==row_max, row=0 and col++.
//    last = (row==row_max) & (col==col_max), registered with the beat.
//    Accepted beat with last=1: out_valid=0, busy=0, next state DONE.
//   DONE: done=1 for exactly one cycle. Next state IDLE.
//  start while busy or in DONE is ignored (no re-latch, no restart).
//  start in the same cycle as the DONE pulse is also ignored.
//  start in the cycle after done is accepted normally.
//  a, row, col and last are registered; all update on the same edge as the handshake. No combinational path from out_ready to outputs.
//  Throughput: one beat per cycle while out_ready=1.
//  Scan length: (row_max+1)*(col_max+1) beats.
//  a = (row << shift) | col, truncated to MSB+1 bits. Caller keeps (row_max+1)<<shift <= 2^(MSB+1).
//  Non-power-of-2 col_max: shift from trailing ones, col still counts to col_max; a is undefined (not checked).
//  1x1 matrix (row_max=col_max=0): single beat, last=1 on first beat.
//  out_ready low for many cycles: beat held, no skipped or duplicated addresses.
// TESTING
//  T1: start, row_max=1, col_max=3, col_major=0, out_ready=1.
//      -> a = 0..7 one per cycle, (row,col) = (0,0)..(1,3), last on a=7, done 1 cycle later.
//  T2: same dims, col_major=1.
//      -> (row,col) = (0,0),(1,0),(0,1),(1,1),...,(1,3); a = 0,4,1,5,2,6,3,7; last on a=7.
//  T3: row_max=2, col_max=1; out_ready toggles 1,0,0,1,... random.
//      -> exactly 6 accepted beats a = 0,1,2,3,4,5.
//      -> outputs stable while valid & !ready; one done pulse.
//  T4: row_max=0, col_max=0.
//      -> one beat a=0, last=1.
//      -> done 1 cycle after accept; busy high for exactly the beat cycle(s).
//  T5: start pulsed during RUN with different dims.
//      -> ignored, original scan completes.
//      -> RST_L low mid-scan: out_valid/busy/done drop to 0 asynchronously; next start restarts at a=0.

Source files
------------

// File: rtl/matrix_addr_reader.sv
// Read-side address sequencer for row/col matrix buffers.
// Streams row, col and linearised address in row- or column-major order.
module matrix_addr_reader #(
    parameter int MSB = 11
) (
    input  logic         CLK,
    input  logic         RST_L,
    input  logic         start,
    input  logic [MSB:0] row_max,
    input  logic [MSB:0] col_max,
    input  logic         col_major,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [MSB:0] a,
    output logic [MSB:0] row,
    output logic [MSB:0] col,
    output logic         last,
    output logic         busy,
    output logic         done
);

    localparam int W  = MSB + 1;
    localparam int SW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [MSB:0]  r_max, r_max_n;
    logic [MSB:0]  c_max, c_max_n;
    logic          cmaj, cmaj_n;
    logic [SW-1:0] shift, shift_n;
    logic [MSB:0]  row_n, col_n, a_n;
    logic          last_n, valid_n, busy_n, done_n;

    logic [SW-1:0] ones;
    logic          ones_run;
    logic [MSB:0]  adv_row, adv_col;

    // Trailing-ones count of col_max gives the column field width
    always_comb begin
        ones     = '0;
        ones_run = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (ones_run && col_max[i]) begin
                ones = ones + 1'b1;
            end else begin
                ones_run = 1'b0;
            end
        end
    end

    // Next element position in the selected scan order
    always_comb begin
        adv_row = row;
        adv_col = col;
        if (!cmaj) begin
            if (col == c_max) begin
                adv_col = '0;
                adv_row = row + 1'b1;
            end else begin
                adv_col = col + 1'b1;
            end
        end else begin
            if (row == r_max) begin
                adv_row = '0;
                adv_col = col + 1'b1;
            end else begin
                adv_row = row + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        r_max_n = r_max;
        c_max_n = c_max;
        cmaj_n  = cmaj;
        shift_n = shift;
        row_n   = row;
        col_n   = col;
        a_n     = a;
        last_n  = last;
        valid_n = out_valid;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    r_max_n = row_max;
                    c_max_n = col_max;
                    cmaj_n  = col_major;
                    shift_n = ones;
                    row_n   = '0;
                    col_n   = '0;
                    a_n     = '0;
                    last_n  = (row_max == '0) && (col_max == '0);
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (out_valid && out_ready) begin
                    if (last) begin
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        row_n  = adv_row;
                        col_n  = adv_col;
                        a_n    = (adv_row << shift) | adv_col;
                        last_n = (adv_row == r_max) && (adv_col == c_max);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Config and beat registers
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_max     <= '0;
            c_max     <= '0;
            cmaj      <= 1'b0;
            shift     <= '0;
            row       <= '0;
            col       <= '0;
            a         <= '0;
            last      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_max     <= r_max_n;
            c_max     <= c_max_n;
            cmaj      <= cmaj_n;
            shift     <= shift_n;
            row       <= row_n;
            col       <= col_n;
            a         <= a_n;
            last      <= last_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_matrix_addr_reader.sv
// Directed bench for matrix_addr_reader.
// Expected beats come from a bench-side order model.
module tb_matrix_addr_reader;

    logic        CLK;
    logic        RST_L;
    logic        start;
    logic [11:0] row_max;
    logic [11:0] col_max;
    logic        col_major;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] a;
    logic [11:0] row;
    logic [11:0] col;
    logic        last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    matrix_addr_reader #(.MSB(11)) dut (
        .CLK       (CLK),
        .RST_L     (RST_L),
        .start     (start),
        .row_max   (row_max),
        .col_max   (col_max),
        .col_major (col_major),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .a         (a),
        .row       (row),
        .col       (col),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_scan(input int rm, input int cm, input bit cmaj,
                            input bit rnd, input bit poke);
        int n, idx, cyc, busy_cyc, er, ec;
        n = (rm + 1) * (cm + 1);
        idx = 0;
        cyc = 0;
        busy_cyc = 0;
        row_max = 12'(rm);
        col_max = 12'(cm);
        col_major = cmaj;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        while (idx < n && cyc < 400) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && idx == 2) begin
                start = 1'b1;
                row_max = 12'd3;
                col_max = 12'd7;
                col_major = ~cmaj;
            end else begin
                start = 1'b0;
            end
            if (!cmaj) begin
                er = idx / (cm + 1);
                ec = idx % (cm + 1);
            end else begin
                ec = idx / (rm + 1);
                er = idx % (rm + 1);
            end
            chk("valid", int'(out_valid), 1);
            chk("a", int'(a), er * (cm + 1) + ec);
            chk("row", int'(row), er);
            chk("col", int'(col), ec);
            chk("last", int'(last), int'(idx == n - 1));
            if (busy) busy_cyc++;
            if (out_ready) idx++;
            @(posedge CLK);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk("beats", idx, n);
        chk("done_pulse", int'(done), 1);
        chk("busy_end", int'(busy), 0);
        chk("valid_end", int'(out_valid), 0);
        if (!rnd) chk("busy_cycles", busy_cyc, n);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        chk("done_clear", int'(done), 0);
        chk("start_in_done_valid", int'(out_valid), 0);
        chk("start_in_done_busy", int'(busy), 0);
        @(posedge CLK);
        #1;
        chk("idle_valid", int'(out_valid), 0);
    endtask

    initial begin
        RST_L = 1'b0;
        start = 1'b0;
        row_max = '0;
        col_max = '0;
        col_major = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_a", int'(a), 0);
        chk("rst_last", int'(last), 0);
        @(negedge CLK);
        RST_L = 1'b1;
        @(posedge CLK);
        #1;

        run_scan(1, 3, 1'b0, 1'b0, 1'b0);
        run_scan(1, 3, 1'b1, 1'b0, 1'b0);
        run_scan(2, 1, 1'b0, 1'b1, 1'b0);
        run_scan(0, 0, 1'b0, 1'b0, 1'b0);
        run_scan(1, 3, 1'b0, 1'b1, 1'b1);
        run_scan(3, 1, 1'b1, 1'b1, 1'b1);

        row_max = 12'd3;
        col_max = 12'd3;
        col_major = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("mid_a", int'(a), 3);
        chk("mid_busy", int'(busy), 1);
        RST_L = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_a", int'(a), 0);
        @(negedge CLK);
        RST_L = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_idle", int'(out_valid), 0);
        run_scan(1, 3, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
